// File: rtl/bram_char_ctrl_if.sv
// Requester-side bundle for the character BRAM controller: the LCD
// character stream, the frame request/done pulses and the host write port.
interface bram_char_ctrl_if #(
    parameter int IDX_W = 5
);
    logic             frame_start;
    logic [7:0]       char_data;
    logic             char_valid;
    logic             char_ready;
    logic             char_last;
    logic             frame_done;
    logic             wr_req;
    logic [IDX_W-1:0] wr_index;
    logic [7:0]       wr_char;
    logic             wr_ack;
    logic             busy;

    // Requester side: LCD writer plus host.
    modport master (
        output frame_start, char_ready, wr_req, wr_index, wr_char,
        input  char_data, char_valid, char_last, frame_done, wr_ack, busy
    );

    // Controller side.
    modport slave (
        input  frame_start, char_ready, wr_req, wr_index, wr_char,
        output char_data, char_valid, char_last, frame_done, wr_ack, busy
    );
endinterface

// File: rtl/bram_char_ctrl.sv
// Sequencer/arbiter for the 4kx4 single-port character BRAM. Each character
// is two nibbles (low at even address, high at odd). The LCD frame fetch and
// host single-character writes share the BRAM, arbitrated at character
// boundaries with alternating priority.
module bram_char_ctrl #(
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter int          CHAR_COUNT = 32,
    parameter int          IDX_W      = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    bram_char_ctrl_if.slave bus,
    output logic [11:0]     bram_addr,
    output logic            bram_en,
    output logic            bram_we,
    output logic [3:0]      bram_di,
    input  logic [3:0]      bram_do,
    output logic            bram_ssr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_RD_CAP,
        S_HOLD,
        S_WR_LO,
        S_WR_HI
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_index;
    logic             r_frame_pend;
    logic             r_last_wr;
    logic [3:0]       r_lo;
    logic [7:0]       r_char_data;
    logic             r_char_valid;
    logic             r_char_last;
    logic             r_frame_done;
    logic             r_wr_ack;

    logic             w_wr_pend;
    logic             w_handshake;
    logic             w_idx_last;
    logic             w_wr_in_range;
    logic             w_sel_wr;
    logic             w_sel_rd;
    logic             w_grant_wr;
    logic             w_grant_rd;
    logic             w_frame_end;
    logic [11:0]      w_rd_addr;
    logic [11:0]      w_wr_addr;

    // The request is still high during the ack cycle; masking it there keeps
    // a completed write from being granted a second time.
    assign w_wr_pend     = bus.wr_req & ~r_wr_ack;
    assign w_handshake   = r_char_valid & bus.char_ready;
    assign w_idx_last    = (r_index == IDX_W'(CHAR_COUNT - 1));
    assign w_wr_in_range = (32'(bus.wr_index) < $unsigned(CHAR_COUNT));

    // Boundary arbitration: a write wins unless a frame is pending and the
    // previous grant already went to a write.
    assign w_sel_wr = w_wr_pend & (~r_frame_pend | ~r_last_wr);
    assign w_sel_rd = ~w_sel_wr & r_frame_pend;

    // Nibble addresses wrap modulo 4096.
    assign w_rd_addr = BASE_ADDR + (12'(r_index) << 1);
    assign w_wr_addr = BASE_ADDR + (12'(bus.wr_index) << 1);

    assign bram_ssr       = 1'b0;
    assign bus.char_data  = r_char_data;
    assign bus.char_valid = r_char_valid;
    assign bus.char_last  = r_char_last;
    assign bus.frame_done = r_frame_done;
    assign bus.wr_ack     = r_wr_ack;
    assign bus.busy       = (r_state != S_IDLE) | r_frame_pend;

    // Next-state, grant and BRAM port decode.
    always_comb begin
        w_next      = r_state;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_frame_end = 1'b0;
        bram_addr   = 12'h000;
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        bram_di     = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_wr) begin
                    w_next     = S_WR_LO;
                    w_grant_wr = 1'b1;
                end else if (w_sel_rd) begin
                    w_next     = S_RD_LO;
                    w_grant_rd = 1'b1;
                end
            end
            S_RD_LO: begin
                bram_addr = w_rd_addr;
                bram_en   = 1'b1;
                w_next    = S_RD_HI;
            end
            S_RD_HI: begin
                bram_addr = w_rd_addr + 12'd1;
                bram_en   = 1'b1;
                w_next    = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_handshake) begin
                    if (w_idx_last) begin
                        w_next      = S_IDLE;
                        w_frame_end = 1'b1;
                    end else if (w_sel_wr) begin
                        w_next     = S_WR_LO;
                        w_grant_wr = 1'b1;
                    end else if (w_sel_rd) begin
                        w_next     = S_RD_LO;
                        w_grant_rd = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_WR_LO: begin
                bram_addr = w_wr_addr;
                bram_di   = bus.wr_char[3:0];
                bram_en   = w_wr_in_range;
                bram_we   = w_wr_in_range;
                w_next    = S_WR_HI;
            end
            S_WR_HI: begin
                bram_addr = w_wr_addr + 12'd1;
                bram_di   = bus.wr_char[7:4];
                bram_en   = w_wr_in_range;
                bram_we   = w_wr_in_range;
                if (r_frame_pend) begin
                    w_next     = S_RD_LO;
                    w_grant_rd = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Frame bookkeeping, arbitration history and handshake pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index      <= '0;
            r_frame_pend <= 1'b0;
            r_last_wr    <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_ack     <= 1'b0;
        end else begin
            if (w_frame_end)          r_frame_pend <= 1'b0;
            else if (bus.frame_start) r_frame_pend <= 1'b1;
            if (w_grant_wr)      r_last_wr <= 1'b1;
            else if (w_grant_rd) r_last_wr <= 1'b0;
            if (w_handshake) r_index <= w_idx_last ? '0 : r_index + 1'b1;
            r_frame_done <= w_frame_end;
            r_wr_ack     <= (r_state == S_WR_HI);
        end
    end

    // Low nibble arrives one cycle after RD_LO presented its address.
    always_ff @(posedge clk) begin
        if (r_state == S_RD_HI) r_lo <= bram_do;
    end

    // Character output register, held stable until the LCD writer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_data  <= 8'h00;
            r_char_valid <= 1'b0;
            r_char_last  <= 1'b0;
        end else if (r_state == S_RD_CAP) begin
            r_char_data  <= {bram_do, r_lo};
            r_char_valid <= 1'b1;
            r_char_last  <= w_idx_last;
        end else if (w_handshake) begin
            r_char_valid <= 1'b0;
            r_char_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_char_ctrl.sv
// Directed bench for bram_char_ctrl with a behavioural RAMB16_S4 model.
module tb_bram_char_ctrl;
    localparam int IDX_W      = 6;
    localparam int CHAR_COUNT = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bram_addr;
    logic        bram_en;
    logic        bram_we;
    logic [3:0]  bram_di;
    logic [3:0]  bram_do;
    logic        bram_ssr;

    logic [3:0]  mem [4096];
    logic        ld_en   = 1'b0;
    logic [11:0] ld_addr = 12'h000;
    logic [3:0]  ld_data = 4'h0;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          we_seen  = 0;
    int          fd_seen  = 0;
    logic [7:0]  exp_chars [32];

    bram_char_ctrl_if #(.IDX_W(IDX_W)) bus ();

    bram_char_ctrl #(
        .BASE_ADDR  (12'h000),
        .CHAR_COUNT (CHAR_COUNT),
        .IDX_W      (IDX_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_di   (bram_di),
        .bram_do   (bram_do),
        .bram_ssr  (bram_ssr)
    );

    always #5 clk = ~clk;

    // BRAM model: 1-cycle registered read, output held while EN=0.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_di;
            bram_do <= bram_we ? bram_di : mem[bram_addr];
        end
        if (bram_we === 1'b1)        we_seen <= we_seen + 1;
        if (bus.frame_done === 1'b1) fd_seen <= fd_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Follow the stream from the current sample until frame_done, comparing
    // every presented character against exp_chars starting at index 'start'.
    task automatic scan_frame(input int start, input int bound, output int end_idx,
                              output int nbad, output int done, output int t_end);
        int idx;
        idx = start; nbad = 0; done = 0; t_end = 0;
        for (int c = 0; c < bound && done == 0; c++) begin
            if (bus.char_valid === 1'b1) begin
                if (idx > 31) nbad++;
                else if (bus.char_data !== exp_chars[idx] ||
                         bus.char_last !== (idx == 31)) nbad++;
                idx++;
            end
            if (bus.frame_done === 1'b1) begin
                done  = 1;
                t_end = cyc;
            end else begin
                tick();
            end
        end
        end_idx = idx;
    endtask

    task automatic read_frame(input int bound, output int end_idx, output int nbad, output int done);
        int t_end;
        bus.char_ready  = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        scan_frame(0, bound, end_idx, nbad, done, t_end);
    endtask

    initial begin
        int n, nbad, done, t0, t_end, fd0, we0, found;

        bus.frame_start = 1'b0;
        bus.char_ready  = 1'b0;
        bus.wr_req      = 1'b0;
        bus.wr_index    = '0;
        bus.wr_char     = 8'h00;
        for (int i = 0; i < 32; i++) exp_chars[i] = (i < 16) ? 8'(8'h41 + i) : 8'h00;

        // Preload the character image while the controller is held in reset.
        ld_en = 1'b1;
        for (int a = 0; a < 64; a++) begin
            ld_addr = 12'(a);
            ld_data = a[0] ? exp_chars[a/2][7:4] : exp_chars[a/2][3:0];
            tick();
        end
        ld_en = 1'b0;

        check("rst_char_valid", bus.char_valid, 0);
        check("rst_char_data",  bus.char_data,  0);
        check("rst_char_last",  bus.char_last,  0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_wr_ack",     bus.wr_ack,     0);
        check("rst_busy",       bus.busy,       0);
        check("rst_bram_en",    bram_en,        0);
        check("rst_bram_we",    bram_we,        0);
        check("rst_bram_addr",  bram_addr,      0);
        check("rst_bram_ssr",   bram_ssr,       0);

        rst_n = 1'b1;
        tick();

        // Full frame, char_ready tied high.
        fd0 = fd_seen;
        bus.char_ready  = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("pend_busy", bus.busy, 1);
        check("pend_idle_en", bram_en, 0);
        tick();
        t0 = cyc;
        check("rdlo_en",   bram_en,   1);
        check("rdlo_we",   bram_we,   0);
        check("rdlo_addr", bram_addr, 12'h000);
        tick();
        check("rdhi_addr", bram_addr, 12'h001);
        tick();
        check("lat_early_valid", bus.char_valid, 0);
        check("rdcap_en", bram_en, 0);
        tick();
        check("lat_valid", bus.char_valid, 1);
        check("first_char", bus.char_data, 8'h41);
        scan_frame(0, 300, n, nbad, done, t_end);
        check("f1_count", n, 32);
        check("f1_bad", nbad, 0);
        check("f1_done", done, 1);
        check("f1_cycles", t_end - t0, 128);
        check("f1_busy_drop", bus.busy, 0);
        tick();
        check("f1_done_pulse_end", bus.frame_done, 0);
        check("f1_done_count", fd_seen - fd0, 1);

        // Backpressure on index 2.
        bus.char_ready  = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        n = 0; found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (bus.char_valid === 1'b1) begin
                if (n == 2) begin
                    bus.char_ready = 1'b0;
                    found = 1;
                end else begin
                    n++;
                end
            end
            if (found == 0) tick();
        end
        check("hold_reached", found, 1);
        nbad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.char_valid !== 1'b1 || bus.char_data !== 8'h43 ||
                bram_en !== 1'b0 || bus.char_last !== 1'b0) nbad++;
        end
        check("hold_stable", nbad, 0);
        bus.char_ready = 1'b1;
        tick();
        check("hold_release", bus.char_valid, 0);
        scan_frame(3, 300, n, nbad, done, t_end);
        check("f2_count", n, 32);
        check("f2_bad", nbad, 0);
        check("f2_done", done, 1);

        // Host write of 0x7C to index 5 while idle.
        bus.wr_req   = 1'b1;
        bus.wr_index = 6'd5;
        bus.wr_char  = 8'h7C;
        tick();
        check("wrlo_addr", bram_addr, 12'h00A);
        check("wrlo_di",   bram_di,   4'hC);
        check("wrlo_we",   bram_we,   1);
        check("wrlo_en",   bram_en,   1);
        tick();
        check("wrhi_addr", bram_addr, 12'h00B);
        check("wrhi_di",   bram_di,   4'h7);
        check("wrhi_we",   bram_we,   1);
        tick();
        check("wr_ack", bus.wr_ack, 1);
        bus.wr_req = 1'b0;
        tick();
        check("wr_ack_pulse", bus.wr_ack, 0);
        exp_chars[5] = 8'h7C;
        read_frame(300, n, nbad, done);
        check("f3_count", n, 32);
        check("f3_bad", nbad, 0);
        check("f3_done", done, 1);

        // Out-of-range index: timing preserved, BRAM untouched.
        we0 = we_seen;
        bus.wr_req   = 1'b1;
        bus.wr_index = 6'd40;
        bus.wr_char  = 8'hFF;
        tick();
        check("oor_lo_en", bram_en, 0);
        tick();
        check("oor_hi_en", bram_en, 0);
        tick();
        check("oor_ack", bus.wr_ack, 1);
        bus.wr_req = 1'b0;
        check("oor_no_we", we_seen - we0, 0);
        tick();

        // Simultaneous frame and write after reset, then alternation.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.char_ready  = 1'b1;
        bus.frame_start = 1'b1;
        bus.wr_req      = 1'b1;
        bus.wr_index    = 6'd3;
        bus.wr_char     = 8'h55;
        tick();
        bus.frame_start = 1'b0;
        check("arb_wr_first_we",   bram_we,   1);
        check("arb_wr_first_addr", bram_addr, 12'h006);
        tick();
        tick();
        check("arb_ack1",     bus.wr_ack, 1);
        check("arb_rd_after", bram_en & ~bram_we, 1);
        check("arb_rd_addr",  bram_addr, 12'h000);
        bus.wr_req = 1'b0;
        tick();
        bus.wr_req   = 1'b1;
        bus.wr_index = 6'd1;
        bus.wr_char  = 8'h66;
        tick();
        tick();
        check("alt_char0_valid", bus.char_valid, 1);
        check("alt_char0_data",  bus.char_data,  8'h41);
        check("alt_held_off",    bram_we,        0);
        tick();
        check("alt_wr2_we",   bram_we,   1);
        check("alt_wr2_addr", bram_addr, 12'h002);
        tick();
        tick();
        check("alt_ack2",    bus.wr_ack, 1);
        check("alt_rd_addr", bram_addr,  12'h002);
        bus.wr_req = 1'b0;
        tick();
        tick();
        tick();
        check("coh_char1", bus.char_data, 8'h66);
        exp_chars[1] = 8'h66;
        exp_chars[3] = 8'h55;
        scan_frame(1, 300, n, nbad, done, t_end);
        check("f4_count", n, 32);
        check("f4_bad", nbad, 0);
        check("f4_done", done, 1);
        tick();

        // Reset asserted during RD_HI abandons the frame.
        fd0 = fd_seen;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        tick();
        check("mid_rdhi_addr", bram_addr, 12'h001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en",    bram_en,        0);
        check("mid_rst_addr",  bram_addr,      0);
        check("mid_rst_busy",  bus.busy,       0);
        check("mid_rst_valid", bus.char_valid, 0);
        tick();
        tick();
        check("mid_rst_no_done", fd_seen - fd0, 0);
        rst_n = 1'b1;
        tick();
        read_frame(300, n, nbad, done);
        check("f5_count", n, 32);
        check("f5_bad", nbad, 0);
        check("f5_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_char_ctrl.md
Name: bram_char_ctrl

Overview:
- Sequencer and arbiter for the 4kx4 single-port character BRAM (RAMB16_S4, 1-cycle registered read, output held while EN=0).
- Each 8-bit character occupies two consecutive nibble addresses: low nibble at even address BASE_ADDR+2*i, high nibble at +1.
- Serves two requesters: the LCD writer, which fetches a full frame of CHAR_COUNT characters over a valid/ready stream, and a host port that overwrites single characters.
- Arbitrates between them at character boundaries with alternating priority.

Parameters:
- BASE_ADDR, 12'h000, nibble address of character 0.
- CHAR_COUNT, 32, characters per frame (1..2^IDX_W).
- IDX_W, 5, width of character index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse, request a frame fetch.
- char_data  out  8  assembled character {hi,lo}.
- char_valid  out  1  char_data valid.
- char_ready  in  1  LCD writer accepts char_data.
- char_last  out  1  qualifies char_valid for index CHAR_COUNT-1.
- frame_done  out  1  one-cycle pulse after the last character is accepted.
- wr_req  in  1  host write request, level, held until wr_ack.
- wr_index  in  IDX_W  character index to write.
- wr_char  in  8  character to write.
- wr_ack  out  1  one-cycle pulse, write completed or discarded.
- busy  out  1  state != IDLE or frame pending.
- bram_addr  out  12  to BRAM ADDR.
- bram_en  out  1  to BRAM EN.
- bram_we  out  1  to BRAM WE.
- bram_di  out  4  to BRAM DI.
- bram_do  in  4  from BRAM DO.
- bram_ssr  out  1  to BRAM SSR, constant 0.

Behaviour:
- Reset (async, rst_n=0): all outputs 0. State=IDLE, index=0, frame_pend=0, last_wr=0.
  - Reset mid-frame or mid-write abandons the operation; no ack and no frame_done are issued.
- frame_start sets frame_pend. It is ignored while a frame is in progress (pend set or fetching).
- States: IDLE, RD_LO, RD_HI, RD_CAP, HOLD, WR_LO, WR_HI.
- Boundary decision, made in IDLE, or in HOLD on handshake when the frame is not finished:
  - Write only pending: go to WR_LO.
  - Frame only pending: go to RD_LO.
  - Both pending: WR_LO if last_wr=0, else RD_LO.
  - last_wr is set on a write grant and cleared on a read grant.
- RD_LO: bram_addr=BASE_ADDR+2*index, en=1, we=0. Next state RD_HI.
- RD_HI: addr+1, en=1. Capture bram_do as low nibble. Next state RD_CAP.
- RD_CAP: en=0. Capture bram_do as high nibble into char_data. Register char_valid=1 and char_last=(index==CHAR_COUNT-1). Next state HOLD.
- Read latency: char_valid rises 3 cycles after the edge that grants RD_LO.
- HOLD: char_data, char_valid and char_last are held stable until char_valid&char_ready. No BRAM access and no write grants occur during HOLD.
  - On handshake: char_valid=0 next cycle, index++.
  - If this was the last character: index=0, frame_pend=0, frame_done pulses the next cycle, go to IDLE. Otherwise make the boundary decision.
- WR_LO: addr=BASE_ADDR+2*wr_index, di=wr_char[3:0], en=1, we=1.
- WR_HI: addr+1, di=wr_char[7:4], en=1, we=1. wr_ack pulses the cycle after WR_HI. Return to RD_LO if a frame is pending, else IDLE.
- wr_index, wr_char and wr_req must be held stable until wr_ack.
- wr_index >= CHAR_COUNT: still passes through WR_LO/WR_HI timing with we=0 and en=0, then wr_ack. BRAM is untouched.
- Address arithmetic is modulo 4096.
- Coherence:
  - A write to an index already fetched in the current frame is visible from the next frame.
  - A write to an index not yet fetched is visible in the current frame.
- Minimum throughput with char_ready tied high: 4 cycles per character, 128 cycles per 32-char frame plus granted writes at 2 cycles each.

Test Plan:
- BRAM model loaded with 0x41..0x50 at indices 0..15 and 0x00 elsewhere; pulse frame_start with char_ready=1 -> 32 chars in order, first char_data=0x41 three cycles after grant, char_last on index 31, single frame_done pulse, busy drops.
- Hold char_ready=0 for 10 cycles on index 2 -> char_data=0x43 and char_valid stable throughout, bram_en=0, no index advance.
- wr_req index 5, char 0x7C while IDLE -> WR_LO addr 0x00A di 0xC we=1, WR_HI addr 0x00B di 0x7, wr_ack one cycle; a following frame returns 0x7C at index 5.
- frame_start and wr_req asserted in the same cycle after reset -> write granted first (last_wr=0); a second write is held off until one character is fetched (alternation).
- wr_index=40 with CHAR_COUNT=32 -> wr_ack after 2 cycles, no cycle with bram_we=1.
- Assert rst_n=0 during RD_HI -> all outputs 0 immediately, no frame_done; a new frame_start restarts at index 0.
